// File: rtl/counter_pkg.sv
// Shared constants for the bounded up/down counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int CNT_W_DEFAULT = 8;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Combinational next-count and boundary detection for bounded_updown_counter.
// Wrap vs. saturate at the bound is selected by the COUNTER_SAT_EN macro.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_W_DEFAULT,
  parameter int MAX_VAL = (2 ** WIDTH) - 1
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             up,
  input  logic             en,
  output logic [WIDTH-1:0] nxt,
  output logic             bnd
);

  localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE_X = (WIDTH + 1)'(1);

  logic [WIDTH:0] cnt_x;

  assign cnt_x = {1'b0, cnt};

  // The wrap point is defined by the MAX_VAL compare, never by the natural
  // 2**WIDTH rollover, so the arithmetic is carried one bit wider.
  always_comb begin
    nxt = cnt;
    bnd = 1'b0;
    if (en) begin
      if (up == DIR_UP) begin
        if (cnt_x == MAX_X) begin
          bnd = 1'b1;
`ifdef COUNTER_SAT_EN
          nxt = cnt;
`else
          nxt = '0;
`endif
        end else begin
          nxt = WIDTH'(cnt_x + ONE_X);
        end
      end else begin
        if (cnt_x == '0) begin
          bnd = 1'b1;
`ifdef COUNTER_SAT_EN
          nxt = '0;
`else
          nxt = WIDTH'(MAX_X);
`endif
        end else begin
          nxt = WIDTH'(cnt_x - ONE_X);
        end
      end
    end
  end

endmodule : counter_next

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with clamped parallel load, enable and overflow pulse.
// Define COUNTER_SAT_EN for saturating bounds; default build wraps.
module bounded_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_W_DEFAULT,
  parameter int MAX_VAL = (2 ** WIDTH) - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("bounded_updown_counter: WIDTH must be at least 1");
    end
    if ((MAX_VAL <= 0) || (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_max
      $error("bounded_updown_counter: MAX_VAL out of range for WIDTH");
    end
    if ((RST_VAL < 0) || (RST_VAL > MAX_VAL)) begin : g_bad_rst
      $error("bounded_updown_counter: RST_VAL must lie in [0, MAX_VAL]");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] v_x;
    v_x = {1'b0, v};
    if (v_x > (WIDTH + 1)'(MAX_VAL)) begin
      return MAX_W;
    end
    return v;
  endfunction

  logic [WIDTH-1:0] cnt_nxt;
  logic             bnd;

  counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .cnt (cnt),
    .up  (up),
    .en  (en),
    .nxt (cnt_nxt),
    .bnd (bnd)
  );

  // Priority: reset > load > enabled step > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= RST_W;
      ovf <= 1'b0;
    end else if (load) begin
      cnt <= clamp_load(load_val);
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= bnd;
    end
  end

  assign tc = ((up == DIR_UP) && (cnt == MAX_W)) || ((up == DIR_DOWN) && (cnt == '0));

endmodule : bounded_updown_counter
